// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      INIT,
      RUN,
      MEM_WAIT
   } ctrl_state_t;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Execute-stage operand forwarding select for one source register.
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              reg_write_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_w,
   output fwd_sel_t          sel
);

   // The memory stage holds the younger result, so it wins over writeback; x0 never forwards.
   always_comb begin
      if (reg_write_m && (rd_m != '0) && (rd_m == rs))
         sel = FWD_MEM;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
         sel = FWD_WB;
      else
         sel = FWD_RF;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: reset flush window, memory-wait FSM,
// branch/load-use resolution, operand forwarding and saturating event counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RESET_FLUSH_CYCLES = 3,
   parameter int CNT_W              = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              reg_write_e,
   input  logic              load_e,
   input  logic              pc_src_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              reg_write_m,
   input  logic              mem_req_m,
   input  logic              mem_ready,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_w,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_w,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [3:0] INIT_LOAD = 4'(RESET_FLUSH_CYCLES);

   ctrl_state_t state, state_nxt;
   logic [3:0]  init_cnt;
   logic        load_use;
   logic        stall_evt;
   logic        flush_evt;
   fwd_sel_t    fwd_a, fwd_b;
   logic        unused_ok;

   // Every load writes rd, so the write enable adds nothing to the load-use test.
   assign unused_ok = reg_write_e;

   assign load_use = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

   pipe_fwd_unit u_fwd_a (
      .rs          (rs1_e),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .sel         (fwd_a)
   );

   pipe_fwd_unit u_fwd_b (
      .rs          (rs2_e),
      .rd_m        (rd_m),
      .reg_write_m (reg_write_m),
      .rd_w        (rd_w),
      .reg_write_w (reg_write_w),
      .sel         (fwd_b)
   );

   assign forward_a_e = fwd_a;
   assign forward_b_e = fwd_b;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      stall_f   = 1'b0;
      stall_d   = 1'b0;
      stall_e   = 1'b0;
      stall_m   = 1'b0;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_w   = 1'b0;
      flush_evt = 1'b0;
      unique case (state)
         INIT: begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
            if (init_cnt <= 4'd1) state_nxt = RUN;
         end
         RUN: begin
            if (mem_req_m && !mem_ready) begin
               state_nxt = MEM_WAIT;
               {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
               flush_w   = 1'b1;
            end else if (pc_src_e) begin
               flush_d   = 1'b1;
               flush_e   = 1'b1;
               flush_evt = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end
         MEM_WAIT: begin
            // The exit cycle releases everything; hazards are re-evaluated once back in RUN.
            if (mem_ready) begin
               state_nxt = RUN;
            end else begin
               {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
               flush_w = 1'b1;
            end
         end
         default: begin
            state_nxt = INIT;
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_w   = 1'b1;
         end
      endcase
   end

   assign stall_evt = (state != INIT) && (stall_f || stall_m);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= INIT;
         init_cnt  <= INIT_LOAD;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
         state <= state_nxt;
         if ((state == INIT) && (init_cnt != 4'd0))
            init_cnt <= init_cnt - 4'd1;
         if (stall_evt && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_evt && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, scoreboard queue and
// hand-written sequences for reset, memory wait and counter saturation.
module tb_pipe_hazard_ctrl;

   localparam int CW = 4;
   localparam logic [CW-1:0] CMAX = '1;

   typedef struct {
      string      name;
      logic [4:0] rs1_d, rs2_d, rd_e, rs1_e, rs2_e, rd_m, rd_w;
      logic       load_e, pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready;
      logic [3:0] stl;  // {stall_f, stall_d, stall_e, stall_m}
      logic [2:0] fls;  // {flush_d, flush_e, flush_w}
      logic [1:0] fa, fb;
   } vec_t;

   typedef struct {
      string      name;
      logic [3:0] stl;
      logic [2:0] fls;
      logic [1:0] fa, fb;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic reg_write_e, load_e, pc_src_e, reg_write_m, mem_req_m, mem_ready, reg_write_w;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
   logic [1:0] forward_a_e, forward_b_e;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   logic [CW-1:0] exp_sc = '0;
   logic [CW-1:0] exp_fc = '0;
   vec_t tbl[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RESET_FLUSH_CYCLES(3), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .reg_write_e(reg_write_e), .load_e(load_e), .pc_src_e(pc_src_e),
      .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
      .rd_w(rd_w), .reg_write_w(reg_write_w),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   function automatic vec_t mk(input string name,
                               input logic [4:0] r1d, input logic [4:0] r2d,
                               input logic ld, input logic [4:0] rde, input logic pc,
                               input logic [4:0] r1e, input logic [4:0] r2e,
                               input logic [4:0] rdm, input logic rwm,
                               input logic [4:0] rdw, input logic rww,
                               input logic req, input logic rdy,
                               input logic [3:0] stl, input logic [2:0] fls,
                               input logic [1:0] fa, input logic [1:0] fb);
      vec_t v;
      v.name = name; v.rs1_d = r1d; v.rs2_d = r2d; v.load_e = ld; v.rd_e = rde;
      v.pc_src_e = pc; v.rs1_e = r1e; v.rs2_e = r2e; v.rd_m = rdm; v.reg_write_m = rwm;
      v.rd_w = rdw; v.reg_write_w = rww; v.mem_req_m = req; v.mem_ready = rdy;
      v.stl = stl; v.fls = fls; v.fa = fa; v.fb = fb;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e;
      load_e = v.load_e; reg_write_e = v.load_e; pc_src_e = v.pc_src_e;
      rd_m = v.rd_m; reg_write_m = v.reg_write_m; mem_req_m = v.mem_req_m;
      mem_ready = v.mem_ready; rd_w = v.rd_w; reg_write_w = v.reg_write_w;
      e.name = v.name; e.stl = v.stl; e.fls = v.fls; e.fa = v.fa; e.fb = v.fb;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of stimulus, compare outputs mid-cycle, then counters after the edge.
   task automatic step(input vec_t v);
      exp_t e;
      drive(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check({e.name, ".stall"}, {28'd0, stall_f, stall_d, stall_e, stall_m}, {28'd0, e.stl});
      check({e.name, ".flush"}, {29'd0, flush_d, flush_e, flush_w}, {29'd0, e.fls});
      check({e.name, ".fwd_a"}, {30'd0, forward_a_e}, {30'd0, e.fa});
      check({e.name, ".fwd_b"}, {30'd0, forward_b_e}, {30'd0, e.fb});
      if ((e.stl[3] || e.stl[0]) && exp_sc != CMAX) exp_sc++;
      if (e.fls[2] && !e.fls[0] && exp_fc != CMAX) exp_fc++;
      @(posedge clk);
      #1;
      check({e.name, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, exp_sc});
      check({e.name, ".flush_cnt"}, {28'd0, flush_cnt}, {28'd0, exp_fc});
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".stall"}, {28'd0, stall_f, stall_d, stall_e, stall_m}, 32'd0);
      check({name, ".flush"}, {29'd0, flush_d, flush_e, flush_w}, 32'd7);
      check({name, ".fwd"}, {28'd0, forward_a_e, forward_b_e}, 32'd0);
      check({name, ".stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
      check({name, ".flush_cnt"}, {28'd0, flush_cnt}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t idle, init_v, lu, br, wait_v, wait_fwd, exit_v;
      idle     = mk("idle",  0,0, 0,0, 0, 0,0, 0,0, 0,0, 0,0, 4'b0000, 3'b000, 2'b00, 2'b00);
      init_v   = mk("init",  0,0, 0,0, 0, 0,0, 0,0, 0,0, 0,0, 4'b0000, 3'b111, 2'b00, 2'b00);
      lu       = mk("lu",    0,5, 1,5, 0, 0,0, 0,0, 0,0, 0,0, 4'b1100, 3'b010, 2'b00, 2'b00);
      br       = mk("br",    0,0, 0,0, 1, 0,0, 0,0, 0,0, 0,0, 4'b0000, 3'b110, 2'b00, 2'b00);
      wait_v   = mk("mwait", 0,5, 1,5, 1, 0,0, 0,0, 0,0, 1,0, 4'b1111, 3'b001, 2'b00, 2'b00);
      wait_fwd = mk("mwfwd", 0,5, 1,5, 1, 7,0, 7,1, 0,0, 1,0, 4'b1111, 3'b001, 2'b10, 2'b00);
      exit_v   = mk("mexit", 0,5, 1,5, 0, 0,0, 0,0, 0,0, 1,1, 4'b0000, 3'b000, 2'b00, 2'b00);

      tbl.push_back(idle);
      tbl.push_back(mk("lu_rs2",   0,5, 1,5, 0, 0,0,   0,0,  0,0,  0,0, 4'b1100, 3'b010, 2'b00, 2'b00));
      tbl.push_back(mk("lu_clear", 0,0, 0,0, 0, 0,0,   0,0,  0,0,  0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
      tbl.push_back(mk("lu_rs1",   9,0, 1,9, 0, 0,0,   0,0,  0,0,  0,0, 4'b1100, 3'b010, 2'b00, 2'b00));
      tbl.push_back(mk("lu_x0",    0,0, 1,0, 0, 0,0,   0,0,  0,0,  0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
      tbl.push_back(mk("no_load",  0,5, 0,5, 0, 0,0,   0,0,  0,0,  0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
      tbl.push_back(mk("branch",   0,0, 0,0, 1, 0,0,   0,0,  0,0,  0,0, 4'b0000, 3'b110, 2'b00, 2'b00));
      tbl.push_back(mk("br_lu",    0,5, 1,5, 1, 0,0,   0,0,  0,0,  0,0, 4'b0000, 3'b110, 2'b00, 2'b00));
      tbl.push_back(mk("fwd_mem",  0,0, 0,0, 0, 7,3,   7,1,  7,1,  0,0, 4'b0000, 3'b000, 2'b10, 2'b00));
      tbl.push_back(mk("fwd_wb",   0,0, 0,0, 0, 7,3,   7,0,  7,1,  0,0, 4'b0000, 3'b000, 2'b01, 2'b00));
      tbl.push_back(mk("fwd_x0",   0,0, 0,0, 0, 0,0,   0,1,  0,1,  0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
      tbl.push_back(mk("fwd_ab_m", 0,0, 0,0, 0, 12,12, 12,1, 12,1, 0,0, 4'b0000, 3'b000, 2'b10, 2'b10));
      tbl.push_back(mk("fwd_b_wb", 0,0, 0,0, 0, 4,12,  4,1,  12,1, 0,0, 4'b0000, 3'b000, 2'b10, 2'b01));
      tbl.push_back(mk("req_rdy",  0,0, 0,0, 0, 0,0,   0,0,  0,0,  1,1, 4'b0000, 3'b000, 2'b00, 2'b00));
      tbl.push_back(mk("req_rdy_lu", 5,0, 1,5, 0, 0,0, 0,0,  0,0,  1,1, 4'b1100, 3'b010, 2'b00, 2'b00));
      tbl.push_back(mk("rdy_br",   0,0, 0,0, 1, 0,0,   0,0,  0,0,  0,1, 4'b0000, 3'b110, 2'b00, 2'b00));

      // Reset and the post-reset flush window.
      reset_n = 1'b0;
      drive(idle);
      void'(exp_q.pop_front());
      #3;
      check_reset_outputs("in_reset");
      @(posedge clk);
      @(posedge clk);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step(init_v);
      step(idle);

      // Single-cycle vector table.
      foreach (tbl[i]) step(tbl[i]);

      // Memory wait: four non-ready cycles, ready exit, then the pending load-use.
      step(wait_v);
      step(wait_fwd);
      step(wait_v);
      step(wait_v);
      step(exit_v);
      step(lu);
      step(idle);

      // Counter saturation.
      for (int i = 0; i < 18; i++) step(lu);
      for (int i = 0; i < 18; i++) step(br);

      // Reset asserted during MEM_WAIT takes effect without a clock edge.
      step(wait_v);
      drive(idle);
      void'(exp_q.pop_front());
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("reset_in_wait");
      exp_sc = '0;
      exp_fc = '0;
      @(posedge clk);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step(init_v);
      step(idle);
      step(lu);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers and the execute-stage forwarding muxes. It sits beside the decode/execute pipeline register, above the datapath. Sequential behaviour covers a post-reset flush window, a memory-wait state machine for multi-cycle data accesses, and saturating performance counters.

## Interface
- RESET_FLUSH_CYCLES, default 3: cycles all stages are flushed after reset release; legal range 1..15.
- CNT_W, default 32: width of the performance counters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; the only clock and reset in the block
- rs1_d, rs2_d  in  5 each  source registers of the instruction in decode
- rs1_e, rs2_e, rd_e  in  5 each  sources and destination in execute
- reg_write_e, load_e  in  1 each  execute instruction writes rd; execute instruction is a load
- pc_src_e  in  1  taken branch/jump resolved in execute
- rd_m, reg_write_m  in  5, 1  memory-stage destination and write enable
- mem_req_m  in  1  memory-stage instruction is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- rd_w, reg_write_w  in  5, 1  writeback destination and write enable
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register
- flush_d, flush_e, flush_w  out  1 each  load a bubble (all zero) into D/E/W register
- forward_a_e, forward_b_e  out  2 each  operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result
- stall_cnt, flush_cnt  out  CNT_W each  saturating counts of stall cycles and flush events

## Operation
- States: INIT, RUN, MEM_WAIT.
  - INIT: loads the counter with RESET_FLUSH_CYCLES. flush_d, flush_e and flush_w are all 1, and every stall is 0. The state moves to RUN when the counter reaches 0.
  - RUN to MEM_WAIT: when mem_req_m=1 and mem_ready=0.
  - MEM_WAIT to RUN: on the first cycle with mem_ready=1.
- MEM_WAIT, and the RUN cycle that causes entry:
  - stall_f, stall_d, stall_e and stall_m are 1.
  - flush_w is 1.
  - Branch and load-use outputs are suppressed; pc_src_e is held upstream by stall_e.
- Load-use, in RUN with no memory wait: the condition is load_e=1, rd_e≠0, and rd_e equals rs1_d or rs2_d. The response is stall_f=1, stall_d=1 and flush_e=1 for exactly that cycle.
- Branch, in RUN with no memory wait: pc_src_e=1 gives flush_d=1 and flush_e=1.
  - Branch overrides load-use: no stall is asserted, because the decode instruction is being discarded.
- Priority: INIT > memory wait > branch > load-use > normal.
- Forwarding is computed per operand, with forward_b_e computed from rs2_e in the same way:
  - forward_a_e = 10 if reg_write_m=1, rd_m≠0 and rd_m==rs1_e.
  - Otherwise forward_a_e = 01 if reg_write_w=1, rd_w≠0 and rd_w==rs1_e.
  - Otherwise forward_a_e = 00.
  - Forwarding is also active during INIT and MEM_WAIT.
- Counters:
  - stall_cnt increments on every cycle in which stall_f=1 or stall_m=1, outside INIT.
  - flush_cnt increments on every cycle with pc_src_e-driven flushes.
  - Both counters saturate at all-ones and never wrap.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state, with zero-cycle latency. No combinational path runs through the counters.
- State and counters update on the rising edge of clk.
- Reset values, asynchronous on reset_n=0:
  - State is INIT and the init counter is RESET_FLUSH_CYCLES.
  - stall_cnt and flush_cnt are 0.
  - While reset_n=0 the outputs are flush_d=flush_e=flush_w=1, all stalls 0, and forward selects 00.
- After reset_n rises, flushes stay high for exactly RESET_FLUSH_CYCLES rising edges, then the state is RUN.
- mem_ready=1 arriving in the same cycle as mem_req_m produces no stall and no MEM_WAIT entry.
- A MEM_WAIT exit cycle (mem_ready=1) releases all stalls in that same cycle, and flush_w=0 in that cycle.
- Reset asserted mid-MEM_WAIT returns the block to INIT immediately; counters clear.
- A load-use hazard pending during MEM_WAIT is evaluated on the RUN cycle after exit.

## Structure
- pipe_ctrl_pkg holds:
  - the fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the ctrl_state_t enum: INIT, RUN, MEM_WAIT;
  - the register-index width constant REG_AW=5.
- Sub-module pipe_fwd_unit is purely combinational. It is instantiated twice, once per operand.
- The FSM, hazard priority logic and counters live in pipe_hazard_ctrl.

## Test plan
- Reset release with RESET_FLUSH_CYCLES=3 → flushes high for 3 edges; cycle 4 shows all stalls and flushes at 0 and the state is RUN.
- load_e=1, rd_e=5, rs2_d=5 → stall_f=stall_d=flush_e=1 for one cycle, then deasserted; with rd_e=0 → no stall.
- load-use and pc_src_e=1 in the same cycle → flush_d=flush_e=1, stall_f=stall_d=0, flush_cnt +1.
- mem_req_m=1, mem_ready=0 for 4 cycles then 1 → stall_f..stall_m and flush_w high for 4 cycles, released on the ready cycle, stall_cnt +4.
- rd_m=7, rd_w=7, both writing, rs1_e=7 → forward_a_e=10; reg_write_m=0 → 01; rs1_e=0 → 00.
- reset_n pulsed low during MEM_WAIT → state INIT, counters 0, flushes high asynchronously.
